// File: rtl/alu_accumulator_if.sv
// Request/response bundle for the ALU accumulator: operation request, result handshake,
// registered result and status flags.
interface alu_accumulator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [2:0]       alu_op;
  logic             src_sel;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             zero_flag;
  logic             neg_flag;
  logic             carry_flag;
  logic             ovf_flag;

  modport master (
    output clear, in_valid, data_in, alu_op, src_sel, sat_en, out_ready,
    input  in_ready, out_valid, data_out, zero_flag, neg_flag, carry_flag, ovf_flag
  );

  modport slave (
    input  clear, in_valid, data_in, alu_op, src_sel, sat_en, out_ready,
    output in_ready, out_valid, data_out, zero_flag, neg_flag, carry_flag, ovf_flag
  );
endinterface

// File: rtl/alu_accumulator.sv
// Single-stage ALU with an accumulator register, valid/ready handshakes on both sides,
// optional unsigned saturation and registered carry/overflow status.
module alu_accumulator #(
  parameter int unsigned     WIDTH    = 8,
  parameter logic [WIDTH-1:0] AND_MASK = {WIDTH/2{2'b10}},
  parameter logic [WIDTH-1:0] OR_MASK  = {WIDTH/2{2'b01}}
) (
  input logic          clk,
  input logic          reset,
  alu_accumulator_if.slave bus
);

  localparam int unsigned    Msb = WIDTH - 1;
  localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] op_a, op_b, result;
  logic [WIDTH:0]   wide;
  logic             arith, is_sub, carry, ovf, accept;

  always_comb begin
    op_a   = bus.src_sel ? data_q : bus.data_in;
    op_b   = bus.data_in;
    wide   = '0;
    arith  = 1'b0;
    is_sub = 1'b0;
    ovf    = 1'b0;
    unique case (bus.alu_op)
      3'b000: begin
        wide  = {1'b0, op_a} + One;
        arith = 1'b1;
        ovf   = ~op_a[Msb] & wide[Msb];
      end
      3'b001: begin
        wide   = {1'b0, op_a} - One;
        arith  = 1'b1;
        is_sub = 1'b1;
        ovf    = op_a[Msb] & ~wide[Msb];
      end
      3'b010: wide = {1'b0, op_a & AND_MASK};
      3'b011: wide = {1'b0, op_a | OR_MASK};
      3'b100: begin
        wide  = {1'b0, op_a} + {1'b0, op_b};
        arith = 1'b1;
        ovf   = (op_a[Msb] == op_b[Msb]) && (wide[Msb] != op_a[Msb]);
      end
      3'b101: begin
        wide   = {1'b0, op_a} - {1'b0, op_b};
        arith  = 1'b1;
        is_sub = 1'b1;
        ovf    = (op_a[Msb] != op_b[Msb]) && (wide[Msb] != op_a[Msb]);
      end
      3'b110: wide = {1'b0, op_a ^ op_b};
      3'b111: wide = {1'b0, op_b};
    endcase
    // Bit WIDTH is carry-out for adds and borrow for subtracts.
    carry  = arith & wide[WIDTH];
    result = wide[Msb:0];
    if (bus.sat_en && carry) begin
      result = is_sub ? '0 : '1;
    end
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    // Clear wins over a simultaneous accept; the request is simply dropped.
    if (bus.clear) begin
      data_d  = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else if (accept) begin
      data_d  = result;
      carry_d = carry;
      ovf_d   = ovf;
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.data_out   = data_q;
  assign bus.carry_flag = carry_q;
  assign bus.ovf_flag   = ovf_q;
  assign bus.zero_flag  = (data_q == '0);
  assign bus.neg_flag   = data_q[Msb];

endmodule

// File: doc/alu_accumulator.md
ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

Interface
REQ-001 Parameter: WIDTH, 8, datapath width; even, >= 4.
REQ-002 Parameter: AND_MASK, {WIDTH/2{2'b10}}, constant for op 010.
REQ-003 Parameter: OR_MASK, {WIDTH/2{2'b01}}, constant for op 011.
REQ-004 Ports: clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 clear  in  1  synchronous clear of result, flags and out_valid.
REQ-007 in_valid  in  1  operation request.
REQ-008 in_ready  out  1  request accepted this cycle when in_valid && in_ready.
REQ-009 data_in  in  WIDTH  operand B; operand A when src_sel=0.
REQ-010 alu_op  in  3  operation select.
REQ-011 src_sel  in  1  0: A = data_in; 1: A = data_out (accumulate).
REQ-012 sat_en  in  1  1: unsigned saturation on arithmetic ops.
REQ-013 out_valid  out  1  data_out/flags hold an unconsumed result.
REQ-014 out_ready  in  1  consumer takes result when out_valid && out_ready.
REQ-015 data_out  out  WIDTH  registered result (accumulator).
REQ-016 zero_flag, neg_flag, carry_flag, ovf_flag  out  1 each  registered status.

Function
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational; no dependency on in_valid).
REQ-018 On accept, result and flags SHALL be registered at that edge; out_valid SHALL be 1 the next cycle (latency 1).
REQ-019 out_valid SHALL fall after out_ready handshake with no new accept in the same cycle; accept plus consume in one cycle SHALL keep out_valid=1 with the new result.
REQ-020 With out_valid=1 and out_ready=0, data_out and all flags SHALL remain stable.
REQ-021 Ops, mod 2^WIDTH: 000 A+1; 001 A-1; 010 A&AND_MASK; 011 A|OR_MASK; 100 A+B; 101 A-B; 110 A^B; 111 B.
REQ-022 Arithmetic ops SHALL compute in WIDTH+1 bits; carry_flag = bit WIDTH (add carry-out, subtract borrow); 0 for ops 010,011,110,111.
REQ-023 ovf_flag SHALL be two's-complement signed overflow for ops 000,001,100,101; 0 otherwise.
REQ-024 sat_en=1: add carry SHALL clamp result to all-ones; subtract borrow SHALL clamp to zero; carry_flag/ovf_flag still report the unclamped event.
REQ-025 zero_flag SHALL equal (data_out == 0); neg_flag SHALL equal data_out[WIDTH-1]; both track data_out at all times.
REQ-026 src_sel=1 SHALL use data_out's value before the accepting edge, irrespective of out_valid.
REQ-027 clear=1 SHALL, at the next edge, set data_out=0, carry/ovf=0, out_valid=0, and take priority over a simultaneous accept (request dropped; in_ready unaffected).

Reset
REQ-028 reset low SHALL immediately force data_out=0, carry_flag=0, ovf_flag=0, out_valid=0; hence zero_flag=1, neg_flag=0, in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard any pending or unconsumed result; first accept after deassertion behaves as from power-up.

Verification
REQ-030 WIDTH=8, reset, out_ready=1; accept op 111 B=0xFF then op 000 src_sel=1 -> data_out 0xFF then 0x00, carry=1, zero=1, ovf=0.
REQ-031 Accumulator 0x7F, op 100 src_sel=1 B=0x01 -> 0x80, ovf=1, neg=1, carry=0; repeat with sat_en=1, acc 0xF0, B=0x20 -> 0xFF, carry=1.
REQ-032 Accumulator 0x05, op 101 src_sel=1 B=0x09, sat_en=1 -> 0x00, carry=1; sat_en=0 -> 0xFC, carry=1, neg=1.
REQ-033 out_ready=0 with result 0x3C pending, in_valid=1 held 3 cycles -> in_ready=0, data_out stays 0x3C; out_ready=1 -> accept and consume same cycle, out_valid stays 1.
REQ-034 Ops 010/011 with data_in=0xFF, WIDTH=8 -> 0xAA and 0xFF; clear with simultaneous accept -> data_out 0x00, out_valid 0; reset pulse mid-burst -> all REQ-028 values at once.
